sync_fifo_core: RTL and testbench
=================================

Name: sync_fifo_core

Overview:
- Single-clock circular-buffer FIFO with registered read data and full/empty flags.
- Queues data words between a producer and a consumer in the same clock domain.
- Uses the same parameter, port and flag conventions as the codebase's asynFIFO, so a bench written for that block ports over with a clock merge.

Parameters:
- data_size, 8, width in bits of each stored word.
- addr_size, 3, address width; depth = 2**addr_size entries (default 8).

Ports:
- clk  input  1  single clock for both the write and read sides; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- write_en  input  1  write request; sampled on the rising clk edge.
- write_data  input  data_size  word to enqueue.
- read_en  input  1  read request; sampled on the rising clk edge.
- read_data  output  data_size  registered dequeued word.
- fifo_empty  output  1  high when no words are stored.
- fifo_full  output  1  high when depth words are stored.
- fifo_level  output  addr_size+1  number of stored words, 0..depth.

Interface (already decided): one clock; reset is asynchronous and active-low. The clock port is clk and the reset port is rst_n.

Behaviour:
- Storage: depth x data_size register array. The array is not reset.
- Pointers: wr_ptr and rd_ptr are addr_size+1 bits wide. The low addr_size bits index the array; the MSB is a wrap bit. Both increment modulo 2**(addr_size+1).
- Flags and level, combinational from the registered pointers:
  - fifo_empty = (wr_ptr == rd_ptr).
  - fifo_full = (MSBs differ) and (low bits equal).
  - fifo_level = wr_ptr - rd_ptr, modulo 2**(addr_size+1).
- Reset, while rst_n is low, immediate and asynchronous:
  - wr_ptr = 0, rd_ptr = 0, read_data = 0.
  - Outputs: fifo_empty = 1, fifo_full = 0, fifo_level = 0.
  - Reset is honoured mid-operation: all stored content becomes logically discarded.
- Write: on a rising edge with write_en = 1 and fifo_full = 0:
  - mem[wr_ptr low bits] <= write_data; wr_ptr increments.
  - Write_en while full is ignored; no state changes.
- Read: on a rising edge with read_en = 1 and fifo_empty = 0:
  - read_data <= mem[rd_ptr low bits]; rd_ptr increments.
  - Latency is one cycle: the word is valid after the edge that accepted the read.
  - read_data holds its last value when no read is accepted, including read_en while empty.
- Simultaneous read and write in the same cycle:
  - Both are accepted when neither is blocked; level is unchanged.
  - When empty: only the write is accepted. No read-through of write_data; empty deasserts after that edge.
  - When full: only the read is accepted; the write is dropped (full blocks the write regardless of a concurrent read).
- Flag timing:
  - fifo_full asserts after the edge that accepts the depth-th outstanding write.
  - fifo_empty asserts after the edge that accepts the read of the last stored word.
- Ordering: strict FIFO order, preserved across pointer wrap-around.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- When defined, two extra output ports exist:
  - overflow (1 bit): sticky; sets on a rising edge with write_en = 1 and fifo_full = 1.
  - underflow (1 bit): sticky; sets on a rising edge with read_en = 1 and fifo_empty = 1.
  - Both clear only on rst_n low and reset to 0.
- When not defined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset: pulse rst_n low mid-cycle -> immediately empty = 1, full = 0, level = 0, read_data = 0.
- Write to full: 8 consecutive writes of random bytes, one per cycle, full checked low before each -> full = 1 and level = 8 after the 8th edge. A 9th write is ignored, level stays 8 (overflow = 1 if FIFO_ERR_FLAGS_EN).
- Read to empty: with read_en pulsed every other cycle, read_data matches the 8 written bytes in order one cycle after each accepted read -> exactly 8 reads until empty = 1.
- Read while empty: read_en = 1 for 3 cycles -> read_data unchanged, pointers unchanged (underflow = 1 if enabled).
- Wrap and simultaneous access: write 5, read 5, then write 8 so the pointers wrap -> full = 1. A simultaneous read+write while full returns the oldest word and drops the write (level 7). Then continuous read+write at level 3 holds level at 3 and preserves order.
- Reset mid-stream: assert rst_n low with level = 4 -> empty = 1 at once. After release, writing 0xA5 and reading it back returns 0xA5.

Source files
------------

// File: rtl/sync_fifo_core.sv
// sync_fifo_core: single-clock circular-buffer FIFO with registered read data.
// Pointers carry one extra wrap bit, so full and empty can be told apart
// without a separate counter. The level output comes from the pointer
// difference.
// Optional build macro FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs.
module sync_fifo_core #(
  parameter int data_size = 8,
  parameter int addr_size = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 write_en,
  input  logic [data_size-1:0] write_data,
  input  logic                 read_en,
  output logic [data_size-1:0] read_data,
  output logic                 fifo_empty,
  output logic                 fifo_full,
`ifdef FIFO_ERR_FLAGS_EN
  output logic                 overflow,
  output logic                 underflow,
`endif
  output logic [addr_size:0]   fifo_level
);

  localparam int depth = 1 << addr_size;
  localparam logic [addr_size:0] ptr_one = {{addr_size{1'b0}}, 1'b1};

  logic [data_size-1:0] mem [depth];
  logic [addr_size:0]   wr_ptr, rd_ptr;
  logic                 wr_ok, rd_ok;

  // Status is derived purely from the registered pointers.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[addr_size] != rd_ptr[addr_size]) &&
                      (wr_ptr[addr_size-1:0] == rd_ptr[addr_size-1:0]);
  assign fifo_level = wr_ptr - rd_ptr;

  // Full blocks writes even when a read is in the same cycle.
  // Empty blocks reads, so write_data never reads through.
  assign wr_ok = write_en && !fifo_full;
  assign rd_ok = read_en && !fifo_empty;

  // Storage array has no reset; content is discarded logically by the pointers.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[addr_size-1:0]] <= write_data;
  end

  // Write pointer advances on every accepted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     wr_ptr <= '0;
    else if (wr_ok) wr_ptr <= wr_ptr + ptr_one;
  end

  // Read pointer and registered read data update only on accepted reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      read_data <= '0;
    end else if (rd_ok) begin
      read_data <= mem[rd_ptr[addr_size-1:0]];
      rd_ptr    <= rd_ptr + ptr_one;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  // Sticky error flags; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_en && fifo_full)  overflow  <= 1'b1;
      if (read_en && fifo_empty)  underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_core.sv
// Bench for sync_fifo_core: a queue-based reference model, a directed
// vector table, plan sequences, and a randomized run.
module tb_sync_fifo_core;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          write_en;
  logic [DW-1:0] write_data;
  logic          read_en;
  logic [DW-1:0] read_data;
  logic          fifo_empty;
  logic          fifo_full;
  logic [AW:0]   fifo_level;
`ifdef FIFO_ERR_FLAGS_EN
  logic          overflow, underflow;
  bit            m_ovf, m_unf;
`endif

  sync_fifo_core #(.data_size(DW), .addr_size(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .write_en(write_en), .write_data(write_data),
    .read_en(read_en), .read_data(read_data),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full),
`ifdef FIFO_ERR_FLAGS_EN
    .overflow(overflow), .underflow(underflow),
`endif
    .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: contents as a queue plus last read word.
  logic [DW-1:0] q [$];
  logic [DW-1:0] m_rd;

  typedef struct {
    bit          we;
    logic [7:0]  wd;
    bit          re;
    int          lvl;
    bit          emp;
    bit          ful;
    logic [7:0]  rd;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("read_data", 32'(read_data), 32'(m_rd));
    chk("empty", 32'(fifo_empty), 32'(q.size() == 0));
    chk("full", 32'(fifo_full), 32'(q.size() == DEPTH));
    chk("level", 32'(fifo_level), 32'(q.size()));
`ifdef FIFO_ERR_FLAGS_EN
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
`endif
  endtask

  // One clock: drive, advance model by the FIFO rules, compare after the edge.
  task automatic cycle(input bit we, input logic [7:0] wd, input bit re);
    bit wacc, racc;
    write_en = we; write_data = wd; read_en = re;
    wacc = we && (q.size() < DEPTH);
    racc = re && (q.size() > 0);
`ifdef FIFO_ERR_FLAGS_EN
    if (we && q.size() == DEPTH) m_ovf = 1'b1;
    if (re && q.size() == 0)     m_unf = 1'b1;
`endif
    if (racc) m_rd = q.pop_front();
    if (wacc) q.push_back(wd);
    @(posedge clk);
    #1;
    chk_model();
  endtask

  // Mid-cycle reset pulse; outputs must clear before any clock edge.
  task automatic pulse_reset();
    write_en = 1'b0; read_en = 1'b0;
    #3 rst_n = 1'b0;
    q.delete();
    m_rd = '0;
`ifdef FIFO_ERR_FLAGS_EN
    m_ovf = 1'b0; m_unf = 1'b0;
`endif
    #1 chk_model();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 chk_model();
  endtask

  initial begin
    logic [7:0] b;
    rst_n = 1'b0; write_en = 1'b0; read_en = 1'b0; write_data = '0;
    m_rd = '0;
`ifdef FIFO_ERR_FLAGS_EN
    m_ovf = 1'b0; m_unf = 1'b0;
`endif
    #2 chk_model();
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, expectations worked out by hand.
    tbl[0] = '{1, 8'h11, 0, 1, 0, 0, 8'h00};
    tbl[1] = '{1, 8'h22, 1, 1, 0, 0, 8'h11};
    tbl[2] = '{0, 8'h00, 1, 0, 1, 0, 8'h22};
    tbl[3] = '{0, 8'h00, 1, 0, 1, 0, 8'h22};
    tbl[4] = '{1, 8'h33, 1, 1, 0, 0, 8'h22};
    tbl[5] = '{0, 8'h00, 1, 0, 1, 0, 8'h33};
    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].we, tbl[i].wd, tbl[i].re);
      chk("tbl_level", 32'(fifo_level), 32'(tbl[i].lvl));
      chk("tbl_empty", 32'(fifo_empty), 32'(tbl[i].emp));
      chk("tbl_full", 32'(fifo_full), 32'(tbl[i].ful));
      chk("tbl_rd", 32'(read_data), 32'(tbl[i].rd));
    end

    pulse_reset();

    // Write to full, then one ignored write.
    for (int i = 0; i < DEPTH; i++) begin
      chk("full_before_wr", 32'(fifo_full), 32'd0);
      cycle(1, 8'($urandom), 0);
    end
    chk("full_after_8", 32'(fifo_full), 32'd1);
    cycle(1, 8'hEE, 0);
    chk("level_after_9th", 32'(fifo_level), 32'(DEPTH));

    // Drain with read_en every other cycle.
    for (int i = 0; i < DEPTH; i++) begin
      chk("empty_during_drain", 32'(fifo_empty), 32'd0);
      cycle(0, 0, 1);
      cycle(0, 0, 0);
    end
    chk("empty_after_8", 32'(fifo_empty), 32'd1);

    // Reads while empty leave everything alone.
    b = read_data;
    for (int i = 0; i < 3; i++) cycle(0, 0, 1);
    chk("rd_hold_empty", 32'(read_data), 32'(b));

    // Wrap: 5 in, 5 out, 8 in.
    for (int i = 0; i < 5; i++) cycle(1, 8'($urandom), 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1);
    for (int i = 0; i < DEPTH; i++) cycle(1, 8'($urandom), 0);
    chk("wrap_full", 32'(fifo_full), 32'd1);
    b = q[0];
    cycle(1, 8'h5A, 1);
    chk("full_rw_oldest", 32'(read_data), 32'(b));
    chk("full_rw_level7", 32'(fifo_level), 32'd7);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1);
    for (int i = 0; i < 12; i++) begin
      cycle(1, 8'($urandom), 1);
      chk("steady_level3", 32'(fifo_level), 32'd3);
    end

    // Reset mid-stream at level 4.
    cycle(1, 8'h01, 0);
    chk("level4_pre_reset", 32'(fifo_level), 32'd4);
    pulse_reset();
    cycle(1, 8'hA5, 0);
    cycle(0, 0, 1);
    chk("post_reset_a5", 32'(read_data), 32'hA5);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++)
      cycle(bit'($urandom_range(0, 1)), 8'($urandom), bit'($urandom_range(0, 1)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
